// File: rtl/xgmii_rx_deframer_pkg.sv
// rtl/xgmii_rx_deframer_pkg.sv - deframer state type, XGMII constants and lane-mask helper
package xgmii_rx_deframer_pkg;

    `include "xgmii_defs.vh"

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_FLUSH,
        S_DROP
    } rx_state_t;

    function automatic logic [63:0] keep_to_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/xgmii_defs.vh
// rtl/xgmii_defs.vh - XGMII control characters and start-word preamble shared by the gmii/xgmii blocks
localparam logic [7:0]  XGMII_IDLE     = 8'h07;
localparam logic [7:0]  XGMII_START    = 8'hFB;
localparam logic [7:0]  XGMII_TERM     = 8'hFD;
localparam logic [7:0]  XGMII_ERROR    = 8'hFE;
// lanes 7..1 of a start word: D5 in lane 7, 55 in lanes 6..1
localparam logic [55:0] XGMII_PREAMBLE = 56'hD5_5555_5555_5555;

// File: rtl/xgmii_term_detect.sv
// rtl/xgmii_term_detect.sv - locates the terminate lane of an XGMII word and flags malformed control lanes
module xgmii_term_detect
    import xgmii_rx_deframer_pkg::*;
(
    input  logic [7:0]  rxc,
    input  logic [63:0] rxd,
    output logic        term_found,
    output logic [2:0]  term_lane,
    output logic        ctrl_err
);

    logic       fd_seen;
    logic       fe_seen;
    logic [7:0] below;

    always_comb begin
        fd_seen   = 1'b0;
        fe_seen   = 1'b0;
        term_lane = 3'd0;
        // scan downwards so the lowest FD control lane wins
        for (int i = 7; i >= 0; i--) begin
            if (rxc[i] && rxd[8*i +: 8] == XGMII_TERM) begin
                fd_seen   = 1'b1;
                term_lane = 3'(i);
            end
            if (rxc[i] && rxd[8*i +: 8] == XGMII_ERROR) begin
                fe_seen = 1'b1;
            end
        end
        below      = (8'h01 << term_lane) - 8'h01;
        term_found = fd_seen && ((rxc | below) == 8'hff);
        ctrl_err   = fe_seen || ((rxc != 8'h00) && (!term_found || ((rxc & below) != 8'h00)));
    end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// rtl/xgmii_rx_deframer.sv - 64-bit XGMII receive deframer producing sop/eop/keep beats and frame statistics
module xgmii_rx_deframer
    import xgmii_rx_deframer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             xgmii_clk,
    input  logic             sys_rst,
    input  logic [7:0]       xgmii_rxc,
    input  logic [63:0]      xgmii_rxd,
    output logic             rx_valid,
    output logic [63:0]      rx_data,
    output logic [7:0]       rx_keep,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic [CNT_W-1:0] rx_frame_cnt,
    output logic [CNT_W-1:0] rx_err_cnt
);

    rx_state_t   state, state_n;
    logic [63:0] held_data, held_data_n;
    logic [7:0]  held_keep, held_keep_n;
    logic        held_valid, held_valid_n;
    logic        first_pend, first_pend_n;

    logic        emit, e_eop, e_err;
    logic [7:0]  e_keep;
    logic        frame_inc, err_inc;

    logic        term_found, ctrl_err;
    logic [2:0]  term_lane;
    logic        is_start, start_ok, idle_word;

    xgmii_term_detect u_term_detect (
        .rxc        (xgmii_rxc),
        .rxd        (xgmii_rxd),
        .term_found (term_found),
        .term_lane  (term_lane),
        .ctrl_err   (ctrl_err)
    );

    always_comb begin
        is_start  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == XGMII_START);
        start_ok  = (xgmii_rxd[63:8] == XGMII_PREAMBLE);
        idle_word = (xgmii_rxc == 8'hff);
        for (int i = 0; i < 8; i++) begin
            if (xgmii_rxd[8*i +: 8] == XGMII_START || xgmii_rxd[8*i +: 8] == XGMII_ERROR) begin
                idle_word = 1'b0;
            end
        end
    end

    always_comb begin
        state_n      = state;
        held_data_n  = held_data;
        held_keep_n  = held_keep;
        held_valid_n = held_valid;
        first_pend_n = first_pend;
        emit         = 1'b0;
        e_eop        = 1'b0;
        e_err        = 1'b0;
        e_keep       = 8'hff;
        frame_inc    = 1'b0;
        err_inc      = 1'b0;

        case (state)
            S_DATA: begin
                if (ctrl_err) begin
                    // a held word closes the frame; otherwise an empty beat carries the error
                    emit         = 1'b1;
                    e_eop        = 1'b1;
                    e_err        = 1'b1;
                    e_keep       = held_valid ? 8'hff : 8'h00;
                    err_inc      = 1'b1;
                    held_valid_n = 1'b0;
                    state_n      = S_DROP;
                end else if (term_found && term_lane == 3'd0) begin
                    emit         = held_valid;
                    e_eop        = 1'b1;
                    frame_inc    = held_valid;
                    err_inc      = !held_valid;
                    held_valid_n = 1'b0;
                    state_n      = S_IDLE;
                end else begin
                    emit         = held_valid;
                    held_valid_n = 1'b1;
                    held_keep_n  = term_found ? ((8'h01 << term_lane) - 8'h01) : 8'hff;
                    held_data_n  = xgmii_rxd & keep_to_mask(held_keep_n);
                    if (term_found) begin
                        state_n = S_FLUSH;
                    end
                end
                if (emit) begin
                    first_pend_n = 1'b0;
                end
            end
            S_FLUSH: begin
                emit         = 1'b1;
                e_eop        = 1'b1;
                e_keep       = held_keep;
                frame_inc    = 1'b1;
                held_valid_n = 1'b0;
                first_pend_n = 1'b0;
                state_n      = S_IDLE;
            end
            S_DROP: begin
                if (idle_word) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // the flush cycle may also carry the next frame's start word
        if ((state == S_IDLE || state == S_FLUSH) && is_start) begin
            if (start_ok) begin
                state_n      = S_DATA;
                first_pend_n = 1'b1;
            end else begin
                state_n = S_DROP;
                err_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            held_data    <= '0;
            held_keep    <= '0;
            held_valid   <= 1'b0;
            first_pend   <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_keep      <= '0;
            rx_sop       <= 1'b0;
            rx_eop       <= 1'b0;
            rx_err       <= 1'b0;
            rx_frame_cnt <= '0;
            rx_err_cnt   <= '0;
        end else begin
            state      <= state_n;
            held_data  <= held_data_n;
            held_keep  <= held_keep_n;
            held_valid <= held_valid_n;
            first_pend <= first_pend_n;
            rx_valid   <= emit;
            rx_data    <= emit ? (held_data & keep_to_mask(e_keep)) : 64'd0;
            rx_keep    <= emit ? e_keep : 8'h00;
            rx_sop     <= emit & first_pend;
            rx_eop     <= emit & e_eop;
            rx_err     <= emit & e_err;
            if (frame_inc) begin
                rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
            end
            if (err_inc) begin
                rx_err_cnt <= rx_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
